// File: rtl/cache_miss_sequencer_pkg.sv
// Shared constants and state encoding for the cache miss sequencer.
// The one-hot state values keep illegal codes easy to recognise and recover from.
package cache_pkg;

   localparam int ADDRESSL  = 15;
   localparam int WORD      = 32;
   localparam int BLOCKSIZE = 4;
   localparam int IDXW      = $clog2(BLOCKSIZE);

   typedef enum logic [4:0] {
      IDLE    = 5'b00001,
      LOOKUP  = 5'b00010,
      FILL    = 5'b00100,
      WRITE   = 5'b01000,
      RESPOND = 5'b10000
   } state_t;

endpackage

// File: rtl/cache_miss_sequencer_if.sv
// Request, cache, RAM and output-mux control pins of the miss sequencer.
// The master side is the surrounding system; the slave side is the sequencer.
interface cache_miss_sequencer_if;
   import cache_pkg::*;

   logic                req_valid;
   logic                req_ready;
   logic                hit;
   logic                r_ack;
   logic                cRead;
   logic                cWrite;
   logic                rRead;
   logic [IDXW-1:0]     fill_idx;
   logic                fill_we;
   logic                selOut;
   logic                resp_valid;
   logic [ADDRESSL-1:0] hit_count;
   logic [ADDRESSL-1:0] miss_count;

   modport master (
      output req_valid, hit, r_ack,
      input  req_ready, cRead, cWrite, rRead, fill_idx, fill_we, selOut,
             resp_valid, hit_count, miss_count
   );

   modport slave (
      input  req_valid, hit, r_ack,
      output req_ready, cRead, cWrite, rRead, fill_idx, fill_we, selOut,
             resp_valid, hit_count, miss_count
   );

endinterface

// File: rtl/cache_miss_sequencer_sat_counter.sv
// Saturating up-counter with increment enable and asynchronous active-low clear.
// Once all ones it holds its value instead of wrapping.
module sat_counter #(
   parameter int W = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/cache_miss_sequencer.sv
// Sequences one cache read at a time: lookup, four-word RAM fill on a miss,
// single-cycle block write, then response from the cache. Counts hits and misses.
module cache_miss_sequencer
   import cache_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   cache_miss_sequencer_if.slave  bus
);

   state_t          state, state_nx;
   logic [IDXW-1:0] fill_idx_q, fill_idx_nx;
   logic            hit_inc, miss_inc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         fill_idx_q <= '0;
      end else begin
         state      <= state_nx;
         fill_idx_q <= fill_idx_nx;
      end
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_nx       = IDLE;
      fill_idx_nx    = fill_idx_q;
      hit_inc        = 1'b0;
      miss_inc       = 1'b0;
      bus.req_ready  = 1'b0;
      bus.cRead      = 1'b0;
      bus.cWrite     = 1'b0;
      bus.rRead      = 1'b0;
      bus.fill_we    = 1'b0;
      bus.selOut     = 1'b0;
      bus.resp_valid = 1'b0;

      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            state_nx      = bus.req_valid ? LOOKUP : IDLE;
         end
         LOOKUP: begin
            bus.cRead  = 1'b1;
            bus.selOut = 1'b1;
            if (bus.hit) begin
               hit_inc  = 1'b1;
               state_nx = RESPOND;
            end else begin
               miss_inc    = 1'b1;
               fill_idx_nx = '0;
               state_nx    = FILL;
            end
         end
         FILL: begin
            bus.rRead = 1'b1;
            state_nx  = FILL;
            if (bus.r_ack) begin
               bus.fill_we = 1'b1;
               // Only the ack of the last word may lead to the block write.
               if (fill_idx_q == IDXW'(BLOCKSIZE - 1))
                  state_nx = WRITE;
               else
                  fill_idx_nx = fill_idx_q + 1'b1;
            end
         end
         WRITE: begin
            bus.cWrite  = 1'b1;
            fill_idx_nx = '0;
            state_nx    = RESPOND;
         end
         RESPOND: begin
            bus.cRead      = 1'b1;
            bus.selOut     = 1'b1;
            bus.resp_valid = 1'b1;
            state_nx       = IDLE;
         end
         default: begin
            fill_idx_nx = '0;
            state_nx    = IDLE;
         end
      endcase
   end

   assign bus.fill_idx = fill_idx_q;

   sat_counter #(.W(ADDRESSL)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit_inc),
      .count (bus.hit_count)
   );

   sat_counter #(.W(ADDRESSL)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss_inc),
      .count (bus.miss_count)
   );

endmodule
